// File: rtl/rf_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rf_pkg : shared sizing helpers for the parametrised register file     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package rf_pkg;

  localparam int MAX_RD = 4;

  function automatic int rf_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

  // LSB of port/register p inside a flat vector of w-bit fields
  function automatic int rf_slice_lsb(input int p, input int w);
    return p * w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_param_read_port.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_param_read_port : one combinational read port (mux, busy,     |
// | optional forwarding when RF_BYPASS_EN is defined)                     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module regfile_param_read_port
  import rf_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 4,
  parameter int ZERO_REG0 = 0
) (
  input  logic [ADDR_W-1:0]                      addr,
  input  logic [rf_depth(ADDR_W)*DATA_W-1:0]     regs,
  input  logic [rf_depth(ADDR_W)-1:0]            busy,
  input  logic                                   wr_en,
  input  logic [ADDR_W-1:0]                      wr_addr,
  input  logic [DATA_W-1:0]                      wr_data,
  input  logic                                   rsv_en,
  input  logic [ADDR_W-1:0]                      rsv_addr,
  output logic [DATA_W-1:0]                      data,
  output logic                                   ready
);

  logic [DATA_W-1:0] w_stored;
  logic              w_stored_ready;

  assign w_stored       = regs[rf_slice_lsb(int'(addr), DATA_W) +: DATA_W];
  assign w_stored_ready = ~busy[addr];

`ifdef RF_BYPASS_EN
  logic w_hit;
  // Hardwired register 0 must never forward the write data it ignores
  assign w_hit = wr_en && (wr_addr == addr) && !((ZERO_REG0 != 0) && (addr == '0));

  always_comb begin
    data  = w_stored;
    ready = w_stored_ready;
    if (w_hit) begin
      data  = wr_data;
      ready = !(rsv_en && (rsv_addr == addr));
    end
  end
`else
  logic unused_bypass;
  assign unused_bypass = ^{wr_en, wr_addr, wr_data, rsv_en, rsv_addr};

  assign data  = w_stored;
  assign ready = w_stored_ready;
`endif

endmodule
`default_nettype wire

// File: rtl/regfile_param.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_param : parametrised register file with busy scoreboard       |
// | Optional same-cycle write forwarding via macro RF_BYPASS_EN.          |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module regfile_param
  import rf_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 4,
  parameter int NUM_RD    = 2,
  parameter int ZERO_REG0 = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_ready,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rsv_en,
  input  logic [ADDR_W-1:0]          rsv_addr,
  output logic [rf_depth(ADDR_W)-1:0] busy_vec
);

  localparam int DEPTH = rf_depth(ADDR_W);

  if (NUM_RD < 1 || NUM_RD > MAX_RD) begin : g_bad_num_rd
    $error("regfile_param: NUM_RD out of range");
  end

  logic [DEPTH*DATA_W-1:0] regs_flat;
  logic [DEPTH-1:0]        busy;

  for (genvar i = 0; i < DEPTH; i++) begin : g_reg
    if ((ZERO_REG0 != 0) && (i == 0)) begin : g_zero
      assign regs_flat[rf_slice_lsb(i, DATA_W) +: DATA_W] = '0;
      assign busy[i] = 1'b0;
    end else begin : g_flop
      logic [DATA_W-1:0] r_data;
      logic              r_busy;
      logic              w_wr_hit;
      logic              w_rsv_hit;

      assign w_wr_hit  = wr_en  && (wr_addr  == ADDR_W'(i));
      assign w_rsv_hit = rsv_en && (rsv_addr == ADDR_W'(i));

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_data <= '0;
          r_busy <= 1'b0;
        end else begin
          if (w_wr_hit) r_data <= wr_data;
          // A new reservation outranks a completing write to the same register
          if (w_rsv_hit)     r_busy <= 1'b1;
          else if (w_wr_hit) r_busy <= 1'b0;
        end
      end

      assign regs_flat[rf_slice_lsb(i, DATA_W) +: DATA_W] = r_data;
      assign busy[i] = r_busy;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    regfile_param_read_port #(
      .DATA_W    (DATA_W),
      .ADDR_W    (ADDR_W),
      .ZERO_REG0 (ZERO_REG0)
    ) u_port (
      .addr     (rd_addr[rf_slice_lsb(p, ADDR_W) +: ADDR_W]),
      .regs     (regs_flat),
      .busy     (busy),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rsv_en   (rsv_en),
      .rsv_addr (rsv_addr),
      .data     (rd_data[rf_slice_lsb(p, DATA_W) +: DATA_W]),
      .ready    (rd_ready[p])
    );
  end

  assign busy_vec = busy;

endmodule
`default_nettype wire

// File: tb/tb_regfile_param.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_regfile_param : directed self-checking bench for regfile_param     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_regfile_param;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rd_addr;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        rsv_en;
  logic [3:0]  rsv_addr;

  logic [31:0] rd_data,  rd_data_z;
  logic [1:0]  rd_ready, rd_ready_z;
  logic [15:0] busy_vec, busy_vec_z;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  regfile_param #(.DATA_W(16), .ADDR_W(4), .NUM_RD(2), .ZERO_REG0(0)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_ready(rd_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_vec(busy_vec)
  );

  regfile_param #(.DATA_W(16), .ADDR_W(4), .NUM_RD(2), .ZERO_REG0(1)) dut_z (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_z), .rd_ready(rd_ready_z),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_vec(busy_vec_z)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then drop the one-shot strobes
  task automatic tick();
    @(posedge clk);
    #1;
    wr_en  = 1'b0;
    rsv_en = 1'b0;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
  endtask

  task automatic do_rsv(input logic [3:0] a);
    rsv_en = 1'b1; rsv_addr = a;
  endtask

  initial begin
    rst = 1'b1; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rsv_en = 1'b0; rsv_addr = '0;

    #2;
    chk("reset_data", rd_data, 32'h0);
    chk("reset_ready", {30'b0, rd_ready}, 32'h3);
    chk("reset_busy", {16'b0, busy_vec}, 32'h0);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // 1. every address reads zero and ready after reset
    for (int a = 0; a < 16; a++) begin
      logic [3:0] av;
      av = 4'(a);
      rd_addr = {av, av};
      #1;
      chk($sformatf("t1_data_a%0d", a), rd_data, 32'h0);
      chk($sformatf("t1_ready_a%0d", a), {30'b0, rd_ready}, 32'h3);
    end
    chk("t1_busy", {16'b0, busy_vec}, 32'h0);

    // 2. write r5, read on both ports next cycle
    do_write(4'd5, 16'hBEEF);
    tick();
    rd_addr = {4'd5, 4'd5};
    #1;
    chk("t2_data", rd_data, 32'hBEEF_BEEF);
    chk("t2_ready", {30'b0, rd_ready}, 32'h3);

    // 3. reserve r7, then complete it with a write
    do_rsv(4'd7);
    tick();
    rd_addr = {4'd7, 4'd7};
    #1;
    chk("t3_busy_set", {16'b0, busy_vec}, 32'h0080);
    chk("t3_ready_lo", {30'b0, rd_ready}, 32'h0);
    do_write(4'd7, 16'h1234);
    tick();
    chk("t3_busy_clr", {16'b0, busy_vec}, 32'h0);
    chk("t3_data", rd_data, 32'h1234_1234);
    chk("t3_ready_hi", {30'b0, rd_ready}, 32'h3);

    // 4. write and reserve r3 together: data lands, busy stays set
    do_write(4'd3, 16'h00AA);
    do_rsv(4'd3);
    tick();
    rd_addr = {4'd3, 4'd3};
    #1;
    chk("t4_data", rd_data, 32'h00AA_00AA);
    chk("t4_busy", {16'b0, busy_vec}, 32'h0008);
    chk("t4_ready", {30'b0, rd_ready}, 32'h0);

    // different addresses act independently; re-reserving r3 keeps it busy
    do_write(4'd5, 16'h1111);
    do_rsv(4'd6);
    tick();
    do_rsv(4'd3);
    tick();
    rd_addr = {4'd6, 4'd5};
    #1;
    chk("t4b_busy", {16'b0, busy_vec}, 32'h0048);
    chk("t4b_data", rd_data, 32'h0000_1111);
    chk("t4b_ready", {30'b0, rd_ready}, 32'h1);

    // 5. hardwired r0 (dut_z) versus ordinary r0 (dut)
    rd_addr = {4'd0, 4'd0};
    do_write(4'd0, 16'hFFFF);
    do_rsv(4'd0);
    #1;
    chk("t5_z_same_cycle", rd_data_z, 32'h0);
    tick();
    chk("t5_z_data", rd_data_z, 32'h0);
    chk("t5_z_ready", {30'b0, rd_ready_z}, 32'h3);
    chk("t5_z_busy0", {31'b0, busy_vec_z[0]}, 32'h0);
    chk("t5_data", rd_data, 32'hFFFF_FFFF);
    chk("t5_busy0", {31'b0, busy_vec[0]}, 32'h1);

    // 6. write r9 while reading it
    rd_addr = {4'd9, 4'd9};
    do_write(4'd9, 16'h5A5A);
    #1;
`ifdef RF_BYPASS_EN
    chk("t6_same_cycle", rd_data, 32'h5A5A_5A5A);
`else
    chk("t6_same_cycle", rd_data, 32'h0);
`endif
    chk("t6_same_ready", {30'b0, rd_ready}, 32'h3);
    tick();
    chk("t6_next_cycle", rd_data, 32'h5A5A_5A5A);

    // reset asserted mid-write discards the write and clears the scoreboard
    do_rsv(4'd9);
    tick();
    chk("t6_busy9", {16'b0, busy_vec}, 32'h0249);
    do_write(4'd9, 16'hFFFF);
    do_rsv(4'd2);
    #2 rst = 1'b1;
    #1;
    wr_en = 1'b0; rsv_en = 1'b0;
    #1;
    chk("t6_rst_data", rd_data, 32'h0);
    chk("t6_rst_busy", {16'b0, busy_vec}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    chk("t6_after_rst_data", rd_data, 32'h0);
    chk("t6_after_rst_ready", {30'b0, rd_ready}, 32'h3);
    do_write(4'd9, 16'h0042);
    tick();
    chk("t6_first_write", rd_data, 32'h0042_0042);
    chk("t6_first_busy", {16'b0, busy_vec}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
